// File: rtl/tpu_pkg.sv
// Shared TPU definitions.
//   MATRIX_WIDTH_DEFAULT      default systolic array edge length
//   EXTENDED_BYTE_WIDTH       one weight element: byte plus sign-extension bit
//   extended_byte_type        one weight element
//   weight_row_type           one row of weights at the default array width
//   weight_loader_state_type  weight_loader FSM states
package tpu_pkg;

    localparam int MATRIX_WIDTH_DEFAULT = 14;
    localparam int BYTE_WIDTH           = 8;
    localparam int EXTENDED_BYTE_WIDTH  = BYTE_WIDTH + 1;

    typedef logic [EXTENDED_BYTE_WIDTH-1:0] extended_byte_type;
    typedef extended_byte_type [MATRIX_WIDTH_DEFAULT-1:0] weight_row_type;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_COMMIT,
        COMMIT
    } weight_loader_state_type;

endpackage

// File: rtl/weight_loader.sv
// weight_loader: streams one weight tile, row by row, into the systolic
// array preweight registers, then commits all of them to the active weights
// in a single cycle once the array allows the swap.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   start        load one tile (only looked at while idle)
//   num_rows     rows actually fetched per tile (WEIGHT_LOADER_ZERO_FILL_EN only)
//   busy         high whenever the loader is not idle
//   done         one-cycle pulse together with load_weight
//   w_valid      upstream row present
//   w_ready      loader takes a row this cycle
//   w_data       one weight row, column c at [c*EXTENDED_BYTE_WIDTH +: EXTENDED_BYTE_WIDTH]
//   weight_out   registered row broadcast to every array row
//   preload_row  one-hot preload strobe, bit r targets array row r
//   load_weight  single-cycle commit of preweights to active weights
//   commit_allow array permits the weight swap
//
// Build option
//   WEIGHT_LOADER_ZERO_FILL_EN: adds num_rows; rows past num_rows are
//   preloaded with zeros, one per cycle, without handshaking upstream.
module weight_loader
    import tpu_pkg::*;
#(
    parameter int MATRIX_WIDTH = MATRIX_WIDTH_DEFAULT
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
    input  logic [$clog2(MATRIX_WIDTH+1)-1:0]           num_rows,
`endif
    output logic                                        busy,
    output logic                                        done,
    input  logic                                        w_valid,
    output logic                                        w_ready,
    input  logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] w_data,
    output logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] weight_out,
    output logic [MATRIX_WIDTH-1:0]                     preload_row,
    output logic                                        load_weight,
    input  logic                                        commit_allow
);

    localparam int CW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(MATRIX_WIDTH - 1);

    weight_loader_state_type state_q, state_d;
    logic [CW-1:0] row_cnt;
    logic          rows_left;  // current row still comes from upstream
    logic          hs;         // row handshake this cycle
    logic          advance;    // a row is preloaded next cycle

`ifdef WEIGHT_LOADER_ZERO_FILL_EN
    localparam int NW = $clog2(MATRIX_WIDTH + 1);
    logic [NW-1:0] rows_lim;

    assign rows_left = NW'(row_cnt) < rows_lim;
`else
    assign rows_left = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        w_ready = 1'b0;
        hs      = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = FETCH;
            end
            FETCH: begin
                w_ready = rows_left;
                hs      = w_valid & rows_left;
                // Past the fetched rows, zero rows are preloaded every cycle.
                advance = hs | ~rows_left;
                if (advance && row_cnt == LAST_ROW) state_d = WAIT_COMMIT;
            end
            WAIT_COMMIT: begin
                if (commit_allow) state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_cnt     <= '0;
            weight_out  <= '0;
            preload_row <= '0;
            load_weight <= 1'b0;
            done        <= 1'b0;
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
            rows_lim    <= NW'(MATRIX_WIDTH);
`endif
        end else begin
            // Strobes are single-cycle; COMMIT can never follow a preload
            // directly because WAIT_COMMIT sits in between.
            preload_row <= '0;
            load_weight <= (state_d == COMMIT);
            done        <= (state_d == COMMIT);
            if (state_q == IDLE && start) begin
                row_cnt <= '0;
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
                if (num_rows == '0 || int'(num_rows) > MATRIX_WIDTH)
                    rows_lim <= NW'(MATRIX_WIDTH);
                else
                    rows_lim <= num_rows;
`endif
            end
            if (advance) begin
                preload_row <= MATRIX_WIDTH'(1) << row_cnt;
                weight_out  <= hs ? w_data : '0;
                row_cnt     <= (row_cnt == LAST_ROW) ? '0 : row_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

    localparam int MW  = 4;
    localparam int EBW = tpu_pkg::EXTENDED_BYTE_WIDTH;
    localparam int RW  = MW * EBW;
    localparam int NV  = 22;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          w_valid = 1'b0;
    logic          commit_allow = 1'b0;
    logic [RW-1:0] w_data = '0;
    logic          busy, done, w_ready, load_weight;
    logic [RW-1:0] weight_out;
    logic [MW-1:0] preload_row;
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
    logic [2:0]    num_rows = '0;
`endif

    weight_loader #(.MATRIX_WIDTH(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef WEIGHT_LOADER_ZERO_FILL_EN
        .num_rows     (num_rows),
`endif
        .busy         (busy),
        .done         (done),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_data       (w_data),
        .weight_out   (weight_out),
        .preload_row  (preload_row),
        .load_weight  (load_weight),
        .commit_allow (commit_allow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, wv, ca;
        int         row;
        logic       b, wr, lw, dn;
        logic [3:0] pre;
        int         wo;
    } vec_t;

    vec_t vecs[NV];
    int checks = 0;
    int errors = 0;

    // Row v: column c holds v*16+c; v=0 means an all-zero row.
    function automatic logic [RW-1:0] mkrow(int v);
        logic [RW-1:0] r = '0;
        if (v != 0)
            for (int c = 0; c < MW; c++) r[c*EBW +: EBW] = EBW'(v * 16 + c);
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, logic b, logic wr, logic [3:0] pre,
                            int wo, logic lw, logic dn);
        chk({tag, " busy"},        64'(busy),        64'(b));
        chk({tag, " w_ready"},     64'(w_ready),     64'(wr));
        chk({tag, " preload_row"}, 64'(preload_row), 64'(pre));
        chk({tag, " weight_out"},  64'(weight_out),  64'(mkrow(wo)));
        chk({tag, " load_weight"}, 64'(load_weight), 64'(lw));
        chk({tag, " done"},        64'(done),        64'(dn));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic setv(int i, logic st, logic wv, int row, logic ca,
                        logic b, logic wr, logic [3:0] pre, int wo,
                        logic lw, logic dn);
        vecs[i].st = st; vecs[i].wv = wv; vecs[i].row = row; vecs[i].ca = ca;
        vecs[i].b = b; vecs[i].wr = wr; vecs[i].pre = pre; vecs[i].wo = wo;
        vecs[i].lw = lw; vecs[i].dn = dn;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // st wv row ca | busy wr pre wo lw dn
        setv( 0, 1, 0, 0, 1,  1, 1, 4'b0000, 0, 0, 0);
        setv( 1, 0, 1, 1, 1,  1, 1, 4'b0001, 1, 0, 0);
        setv( 2, 0, 1, 2, 1,  1, 1, 4'b0010, 2, 0, 0);
        setv( 3, 0, 1, 3, 1,  1, 1, 4'b0100, 3, 0, 0);
        setv( 4, 0, 1, 4, 1,  1, 0, 4'b1000, 4, 0, 0);
        setv( 5, 0, 0, 0, 1,  1, 0, 4'b0000, 4, 1, 1);
        setv( 6, 1, 0, 0, 1,  0, 0, 4'b0000, 4, 0, 0);  // start in COMMIT ignored
        setv( 7, 1, 0, 0, 1,  1, 1, 4'b0000, 4, 0, 0);  // start right after done
        setv( 8, 1, 1, 5, 1,  1, 1, 4'b0001, 5, 0, 0);  // start in FETCH ignored
        setv( 9, 0, 1, 6, 1,  1, 1, 4'b0010, 6, 0, 0);
        setv(10, 0, 0, 0, 1,  1, 1, 4'b0000, 6, 0, 0);  // 3-cycle stall
        setv(11, 0, 0, 0, 1,  1, 1, 4'b0000, 6, 0, 0);
        setv(12, 0, 0, 0, 1,  1, 1, 4'b0000, 6, 0, 0);
        setv(13, 0, 1, 7, 0,  1, 1, 4'b0100, 7, 0, 0);
        setv(14, 0, 1, 8, 0,  1, 0, 4'b1000, 8, 0, 0);
        setv(15, 0, 0, 0, 0,  1, 0, 4'b0000, 8, 0, 0);  // commit held off
        setv(16, 1, 0, 0, 0,  1, 0, 4'b0000, 8, 0, 0);  // start in WAIT_COMMIT ignored
        setv(17, 0, 0, 0, 0,  1, 0, 4'b0000, 8, 0, 0);
        setv(18, 0, 0, 0, 0,  1, 0, 4'b0000, 8, 0, 0);
        setv(19, 0, 0, 0, 0,  1, 0, 4'b0000, 8, 0, 0);
        setv(20, 0, 0, 0, 1,  1, 0, 4'b0000, 8, 1, 1);
        setv(21, 0, 0, 0, 0,  0, 0, 4'b0000, 8, 0, 0);

        // Reset state
        rst = 1'b0;
        step();
        step();
        chk_outs("reset", 0, 0, 4'b0000, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            start        = vecs[i].st;
            w_valid      = vecs[i].wv;
            w_data       = vecs[i].wv ? mkrow(vecs[i].row) : mkrow(31);
            commit_allow = vecs[i].ca;
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].b, vecs[i].wr,
                     vecs[i].pre, vecs[i].wo, vecs[i].lw, vecs[i].dn);
        end
        start = 1'b0;

        // Reset after the second handshake discards the partial tile
        start = 1'b1;
        step();
        start = 1'b0;
        w_valid = 1'b1;
        w_data = mkrow(1);
        step();
        w_data = mkrow(2);
        step();
        chk("pre-reset preload_row", 64'(preload_row), 64'(4'b0010));
        rst = 1'b0;
        w_data = mkrow(3);
        commit_allow = 1'b1;
        step();
        chk_outs("midreset", 0, 0, 4'b0000, 0, 0, 0);
        rst = 1'b1;
        w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-reset%0d load_weight", i), 64'(load_weight), 64'(0));
            chk($sformatf("post-reset%0d busy", i), 64'(busy), 64'(0));
        end

        // Fresh tile after reset, w_valid held high
        start = 1'b1;
        step();
        start = 1'b0;
        for (int r = 0; r < MW; r++) begin
            w_valid = 1'b1;
            w_data = mkrow(r + 9);
            step();
            chk($sformatf("fresh row%0d preload_row", r), 64'(preload_row), 64'(4'b0001 << r));
            chk($sformatf("fresh row%0d weight_out", r), 64'(weight_out), 64'(mkrow(r + 9)));
        end
        w_valid = 1'b0;
        begin
            int n = 0;
            while (!load_weight && n < 8) begin
                step();
                n++;
            end
            chk("fresh load_weight latency", 64'(n), 64'(1));
            chk("fresh done", 64'(done), 64'(1));
            chk("fresh preload at commit", 64'(preload_row), 64'(0));
        end
        step();
        chk("fresh back to idle", 64'(busy), 64'(0));

`ifdef WEIGHT_LOADER_ZERO_FILL_EN
        // Two fetched rows, then two zero rows preloaded without handshake
        num_rows = 3'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        num_rows = 3'd0;
        chk("zf start w_ready", 64'(w_ready), 64'(1));
        w_valid = 1'b1;
        w_data = mkrow(1);
        step();
        chk_outs("zf row0", 1, 1, 4'b0001, 1, 0, 0);
        w_data = mkrow(2);
        step();
        chk_outs("zf row1", 1, 0, 4'b0010, 2, 0, 0);
        w_data = mkrow(12);
        step();
        chk_outs("zf row2", 1, 0, 4'b0100, 0, 0, 0);
        step();
        chk_outs("zf row3", 1, 0, 4'b1000, 0, 0, 0);
        w_valid = 1'b0;
        step();
        chk_outs("zf commit", 1, 0, 4'b0000, 0, 1, 1);
        step();
        chk("zf idle", 64'(busy), 64'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter MATRIX_WIDTH, default 14, meaning number of MAC rows and columns in the systolic array.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to load one weight tile; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 done  output  1  one-cycle pulse, coincident with load_weight.
REQ-007 w_valid  input  1  upstream row available.
REQ-008 w_ready  output  1  loader accepts a row; handshake = w_valid & w_ready.
REQ-009 w_data  input  MATRIX_WIDTH*EXTENDED_BYTE_WIDTH  one weight row; column c in bits [c*EXTENDED_BYTE_WIDTH +: EXTENDED_BYTE_WIDTH].
REQ-010 weight_out  output  MATRIX_WIDTH*EXTENDED_BYTE_WIDTH  registered row broadcast to every row's weight_in.
REQ-011 preload_row  output  MATRIX_WIDTH  one-hot preload_weight strobe, bit r drives row r.
REQ-012 load_weight  output  1  single-cycle commit of all preweights into active weights.
REQ-013 commit_allow  input  1  array permits weight swap; load_weight never asserted while low.

Function
REQ-014 States: IDLE, FETCH, WAIT_COMMIT, COMMIT; encoding free.
REQ-015 IDLE: w_ready=0; start=1 -> FETCH, row counter cleared to 0.
REQ-016 FETCH: w_ready=1 combinationally from state; each handshake captures w_data into weight_out and sets preload_row to one-hot(row counter) in the following cycle only; counter increments.
REQ-017 preload_row SHALL be all-zero in any cycle not immediately following a handshake.
REQ-018 Rows are loaded in order 0..MATRIX_WIDTH-1; handshake on row MATRIX_WIDTH-1 -> WAIT_COMMIT, counter wraps to 0.
REQ-019 w_valid low in FETCH: stall, no preload, counter and weight_out hold.
REQ-020 WAIT_COMMIT: w_ready=0; commit_allow=1 -> COMMIT; otherwise hold indefinitely.
REQ-021 COMMIT: load_weight=1 and done=1 for exactly one cycle, then IDLE; load_weight never in the same cycle as any preload_row bit.
REQ-022 Minimum latency: last-row handshake at cycle t -> preload_row[MATRIX_WIDTH-1] at t+1 -> load_weight at t+2 when commit_allow high at t+1.
REQ-023 start outside IDLE ignored; start in the cycle after done accepted.
REQ-024 All outputs registered except w_ready and busy (decoded from state register).

Reset
REQ-025 rst=0 at any clock edge, including mid-FETCH: state IDLE, counter 0, weight_out 0, preload_row 0, load_weight 0, done 0; partially fetched tile discarded, no commit issued.

Configuration
REQ-026 Macro WEIGHT_LOADER_ZERO_FILL_EN: when defined, adds input num_rows (clog2(MATRIX_WIDTH+1) bits, sampled at start); after num_rows handshakes, remaining rows are preloaded one per cycle with weight_out=0 and w_ready=0; num_rows=0 or >MATRIX_WIDTH treated as MATRIX_WIDTH.
REQ-027 Without the macro: no num_rows port; exactly MATRIX_WIDTH handshakes per tile.

Structure
REQ-028 tpu_pkg holds MATRIX_WIDTH default, EXTENDED_BYTE_WIDTH, extended_byte_type, a new weight_row_type (MATRIX_WIDTH x extended_byte_type) and weight_loader_state_type enum.
REQ-029 No sub-module; FSM, counter and one-hot decode inline.

Verification (MATRIX_WIDTH=4)
REQ-030 start, w_valid held high, rows 0x01..0x04, commit_allow=1 -> preload_row 0001,0010,0100,1000 on consecutive cycles with weight_out matching, load_weight+done two cycles after last handshake.
REQ-031 w_valid low for 3 cycles between rows 1 and 2 -> no preload during gap, order and data unchanged.
REQ-032 commit_allow low 5 cycles after last row -> busy=1, load_weight=0 throughout, asserted 1 cycle after commit_allow rises.
REQ-033 rst=0 after second handshake -> all outputs 0 next cycle, busy=0, no load_weight; fresh start completes normally.
REQ-034 start pulsed during FETCH and WAIT_COMMIT -> ignored; start the cycle after done -> new tile begins.
REQ-035 With WEIGHT_LOADER_ZERO_FILL_EN, num_rows=2 -> two handshakes, then preload_row 0100 and 1000 with weight_out=0, then load_weight.
